// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e        : converter FSM states (IDLE, SHIFT, DONE)
//   bcd_digit_t    : one packed BCD digit
//   BCD_MAX_DIGIT  : largest legal value of a BCD digit
//   min_digits()   : smallest digit count that holds 2**bin_w-1 without overflow
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    // Smallest d such that 10**d > 2**bin_w - 1.
    function automatic int min_digits(input int bin_w);
        longint max_val;
        longint lim;
        int     d;
        max_val = (longint'(1) << bin_w) - 1;
        lim     = 10;
        d       = 1;
        for (int i = 0; i < 19; i++) begin
            if (lim <= max_val) begin
                lim = lim * 10;
                d   = d + 1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle for bin_to_bcd_seq.
//   in_valid/in_ready/in_bin      : operand side (master drives valid + data)
//   out_valid/out_ready           : result side (master drives ready)
//   out_bcd/out_ovf               : packed BCD result, digit 0 in [3:0], overflow flag
// master = upstream producer / downstream consumer; slave = the converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_ovf;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, out_bcd, out_ovf
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, out_bcd, out_ovf
    );
endinterface

// File: rtl/bin_to_bcd_seq_add3.sv
// bcd_add3: single-digit shift-add-3 corrector.
//   d_in  : BCD digit before the shift
//   d_out : d_in + 3 when d_in >= 5 (4-bit wrap, no carry), else d_in
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t d_in,
    output bcd_digit_t d_out
);
    assign d_out = (d_in >= 4'd5) ? (d_in + 4'd3) : d_in;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter, one shift-add-3 step per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of bin_to_bcd_seq_if (in_valid/in_ready/in_bin,
//         out_valid/out_ready/out_bcd/out_ovf)
// One conversion in flight; in_ready is high only in IDLE, out_valid only in DONE.
// Optional build macro BIN2BCD_SKIP_LZ_EN: strip leading zeros of the operand on
// accept so small values finish sooner (zero goes straight to DONE). Results are
// identical either way; only latency changes.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic               clk,
    input  logic               rst,
    bin_to_bcd_seq_if.slave    bus
);
    localparam int CW = $clog2(BIN_W + 1);
    // With enough digits the overflow flag can never set; tie it off so it trims away.
    localparam bit DIGITS_ADEQUATE = (DIGITS >= min_digits(BIN_W));

    state_e               state_q, state_d;
    logic [BIN_W-1:0]     shreg_q, shreg_d;
    logic [4*DIGITS-1:0]  bcd_q, bcd_d;
    logic                 ovf_q, ovf_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  out_bcd_q, out_bcd_d;
    logic                 out_ovf_q, out_ovf_d;

    logic [4*DIGITS-1:0]  bcd_adj;
    logic [BIN_W-1:0]     load_shreg;
    logic [CW-1:0]        load_cnt;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_add3 u_add3 (
                .d_in  (bcd_q[4*gi +: 4]),
                .d_out (bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

`ifdef BIN2BCD_SKIP_LZ_EN
    logic [CW-1:0] lzc;

    // Leading-zero count: the highest set bit wins because it is visited last.
    always_comb begin
        lzc = CW'(BIN_W);
        for (int i = 0; i < BIN_W; i++) begin
            if (bus.in_bin[i]) begin
                lzc = CW'(BIN_W - 1 - i);
            end
        end
    end

    assign load_shreg = bus.in_bin << lzc;
    assign load_cnt   = CW'(BIN_W) - lzc;
`else
    assign load_shreg = bus.in_bin;
    assign load_cnt   = CW'(BIN_W);
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        out_bcd_d = out_bcd_q;
        out_ovf_d = out_ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_d = load_shreg;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = load_cnt;
                    if (load_cnt == '0) begin
                        // Zero operand with nothing left to shift: result is 0.
                        out_bcd_d = '0;
                        out_ovf_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                // Correct every digit, then shift {ovf, bcd, shreg} left by one.
                shreg_d = shreg_q << 1;
                bcd_d   = {bcd_adj[4*DIGITS-2:0], shreg_q[BIN_W-1]};
                ovf_d   = DIGITS_ADEQUATE ? 1'b0 : (ovf_q | bcd_adj[4*DIGITS-1]);
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    // Publish only at the end so out_bcd keeps the last result meanwhile.
                    out_bcd_d = bcd_d;
                    out_ovf_d = ovf_d;
                    state_d   = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            out_bcd_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            out_bcd_q <= out_bcd_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_bcd   = out_bcd_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule
